freq_sweeper: RTL and testbench

- Stepped frequency-sweep controller that pops one 80-bit sweep instruction from a first-word-fall-through FIFO.
- Drives a 32-bit DDS frequency tuning word through NUM_STEPS equal increments, holding each value for a programmable number of clock cycles.
- Sits between the instruction FIFO and the DDS sine generator. The downstream phase detector consumes the DDS output; sweep_start and sweep_done frame each sweep.

---
 rtl/freq_sweeper_pkg.sv | 38 +++
 rtl/freq_sweeper_counter.sv | 48 ++++
 rtl/freq_sweeper.sv | 99 +++++++++
 tb/tb_freq_sweeper.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/freq_sweeper_pkg.sv
// Shared types and constants for the stepped frequency-sweep controller.
// The 80-bit instruction word is {init_freq, cycles_per_step, freq_step}.
package freq_sweeper_pkg;

    localparam int FREQ_W   = 32;
    localparam int CYC_W    = 16;
    localparam int INSTR_W  = 2 * FREQ_W + CYC_W;
    localparam int INIT_LSB = 48;
    localparam int CYC_LSB  = 32;
    localparam int STEP_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [FREQ_W-1:0] init_freq;
        logic [CYC_W-1:0]  cycles_per_step;
        logic [FREQ_W-1:0] freq_step;
    } instr_t;

    function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] word);
        instr_t r;
        r.init_freq       = word[INIT_LSB +: FREQ_W];
        r.cycles_per_step = word[CYC_LSB +: CYC_W];
        r.freq_step       = word[STEP_LSB +: FREQ_W];
        return r;
    endfunction

    // A dwell of zero cycles is meaningless, so it is promoted to one.
    function automatic logic [CYC_W-1:0] eff_cycles(input logic [CYC_W-1:0] cyc);
        return (cyc == '0) ? CYC_W'(1) : cyc;
    endfunction

endpackage

// File: rtl/freq_sweeper_counter.sv
// Dwell/step counter pair: counts cycles within a step and steps within a sweep.
// step_adv and sweep_end flag the last dwell cycle of a non-final and the final step.
module freq_sweeper_counter
    import freq_sweeper_pkg::*;
#(
    parameter int NUM_STEPS = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CYC_W-1:0] dwell_len,
    output logic             step_adv,
    output logic             sweep_end
);

    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    logic [CYC_W-1:0]  dwell_cnt;
    logic [STEP_W-1:0] step_idx;
    logic              dwell_last;
    logic              step_last;

    assign dwell_last = (dwell_cnt == dwell_len - CYC_W'(1));
    assign step_last  = (step_idx == STEP_W'(NUM_STEPS - 1));
    assign step_adv   = enable && dwell_last && !step_last;
    assign sweep_end  = enable && dwell_last && step_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt <= '0;
            step_idx  <= '0;
        end else if (clear) begin
            dwell_cnt <= '0;
            step_idx  <= '0;
        end else if (enable) begin
            if (dwell_last) begin
                dwell_cnt <= '0;
                if (!step_last) begin
                    step_idx <= step_idx + STEP_W'(1);
                end
            end else begin
                dwell_cnt <= dwell_cnt + CYC_W'(1);
            end
        end
    end

endmodule

// File: rtl/freq_sweeper.sv
// Stepped frequency-sweep controller: pops one instruction from a FWFT FIFO and
// walks the DDS tuning word through NUM_STEPS equal increments, each held eff_cycles.
module freq_sweeper
    import freq_sweeper_pkg::*;
#(
    parameter int NUM_STEPS = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    output logic [FREQ_W-1:0]  dds_freq,
    output logic               sweep_start,
    output logic               sweep_done
);

    state_t            state_q, state_d;
    instr_t            instr_q, instr_d;
    logic              rd_en_d, start_d, done_d;
    logic [FREQ_W-1:0] freq_d;
    logic              cnt_clear, cnt_enable;
    logic              step_adv, sweep_end;

    freq_sweeper_counter #(
        .NUM_STEPS (NUM_STEPS)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .enable    (cnt_enable),
        .dwell_len (eff_cycles(instr_q.cycles_per_step)),
        .step_adv  (step_adv),
        .sweep_end (sweep_end)
    );

    // Strobes are set on the transition into the state they frame, so
    // sweep_start coincides with the first SWEEP cycle and sweep_done with DONE.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        rd_en_d    = 1'b0;
        start_d    = 1'b0;
        done_d     = 1'b0;
        freq_d     = dds_freq;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    instr_d = unpack_instr(fifo_data);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                freq_d    = instr_q.init_freq;
                start_d   = 1'b1;
                cnt_clear = 1'b1;
                state_d   = SWEEP;
            end
            SWEEP: begin
                cnt_enable = 1'b1;
                if (step_adv) begin
                    freq_d = dds_freq + instr_q.freq_step;
                end
                if (sweep_end) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            fifo_rd_en  <= 1'b0;
            dds_freq    <= '0;
            sweep_start <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            fifo_rd_en  <= rd_en_d;
            dds_freq    <= freq_d;
            sweep_start <= start_d;
            sweep_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_freq_sweeper.sv
// Bench for freq_sweeper: table vectors, randomized sweeps against an arithmetic
// model, back-to-back pops, and reset abort with a pending FIFO word.
module tb_freq_sweeper;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [79:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] dds_freq;
    logic        sweep_start;
    logic        sweep_done;

    always #10 clk = ~clk;

    freq_sweeper #(.NUM_STEPS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_data   (fifo_data),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .dds_freq    (dds_freq),
        .sweep_start (sweep_start),
        .sweep_done  (sweep_done)
    );

    typedef struct {
        logic [31:0] init;
        logic [15:0] cyc;
        logic [31:0] step;
        logic [31:0] exp_second;
        logic [31:0] exp_final;
    } vec_t;

    vec_t        vecs[4];
    logic [79:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic void refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 80'd0 : fifo_q[0];
    endfunction

    function automatic void push_word(input logic [31:0] init, input logic [15:0] cyc,
                                      input logic [31:0] step);
        fifo_q.push_back({init, cyc, step});
        refresh_fifo();
    endfunction

    // Advance to the next falling edge; the FWFT FIFO model pops on a visible rd_en.
    task automatic tick();
        @(negedge clk);
        if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh_fifo();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {29'd0, fifo_rd_en, sweep_start, sweep_done};
    endfunction

    // Expects the pop strobe on the very next falling edge, then checks every cycle of
    // the sweep against the model, the sweep_done cycle, and one hold cycle after it.
    task automatic run_sweep(input logic [31:0] init, input logic [15:0] cyc,
                             input logic [31:0] step, input logic [31:0] exp_second,
                             input logic [31:0] exp_final, input bit has_table);
        int          e;
        int          waited;
        logic [31:0] fin;
        e = (cyc == 16'd0) ? 1 : int'(cyc);
        fin = init + step * 32'(N - 1);
        waited = 1;
        tick();
        while (fifo_rd_en !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check("pop_latency", 32'(waited), 32'd1);
        check("pop_strobe", strobes(), 32'b100);
        exp_q.delete();
        for (int k = 0; k < N * e; k++) exp_q.push_back(init + step * 32'(k / e));
        for (int k = 0; k < N * e; k++) begin
            tick();
            check("sweep_freq", dds_freq, exp_q.pop_front());
            check("sweep_strobes", strobes(), (k == 0) ? 32'b010 : 32'b000);
            if (has_table && k == e) check("second_freq", dds_freq, exp_second);
        end
        tick();
        check("done_strobe", strobes(), 32'b001);
        check("final_freq", dds_freq, has_table ? exp_final : fin);
        tick();
        check("post_done_strobes", strobes(), 32'b000);
        check("hold_freq", dds_freq, fin);
    endtask

    initial begin
        vecs[0] = '{32'h0100_0000, 16'd16, 32'h0001_0000, 32'h0101_0000, 32'h04FF_0000};
        vecs[1] = '{32'h0000_0000, 16'd4,  32'h0000_0001, 32'h0000_0001, 32'h0000_03FF};
        vecs[2] = '{32'hFFFF_FFF0, 16'd1,  32'h0000_0010, 32'h0000_0000, 32'h0000_3FE0};
        vecs[3] = '{32'h1234_5678, 16'd0,  32'h0000_0100, 32'h1234_5778, 32'h1238_5578};
        refresh_fifo();

        // Reset held for two cycles with an empty FIFO.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_strobes", strobes(), 32'b000);
            check("reset_freq", dds_freq, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_empty_strobes", strobes(), 32'b000);
        end

        // First vector pushed alone, the rest queued so they pop back-to-back.
        push_word(vecs[0].init, vecs[0].cyc, vecs[0].step);
        run_sweep(vecs[0].init, vecs[0].cyc, vecs[0].step, vecs[0].exp_second,
                  vecs[0].exp_final, 1'b1);
        for (int i = 1; i < 4; i++) push_word(vecs[i].init, vecs[i].cyc, vecs[i].step);
        for (int i = 1; i < 4; i++) begin
            run_sweep(vecs[i].init, vecs[i].cyc, vecs[i].step, vecs[i].exp_second,
                      vecs[i].exp_final, 1'b1);
        end
        tick();
        check("idle_after_queue", strobes(), 32'b000);

        // Randomized sweeps, queued together.
        begin
            logic [31:0] r_init[4];
            logic [15:0] r_cyc[4];
            logic [31:0] r_step[4];
            for (int i = 0; i < 4; i++) begin
                r_init[i] = $urandom;
                r_cyc[i]  = 16'($urandom_range(0, 4));
                r_step[i] = $urandom;
                push_word(r_init[i], r_cyc[i], r_step[i]);
            end
            for (int i = 0; i < 4; i++) begin
                run_sweep(r_init[i], r_cyc[i], r_step[i], 32'd0, 32'd0, 1'b0);
            end
        end
        tick();

        // Reset mid-sweep with a second word pending in the FIFO.
        push_word(32'hA000_0000, 16'd3, 32'h0000_0005);
        tick();
        check("abort_pop_strobe", strobes(), 32'b100);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 10) push_word(32'h0BAD_0000, 16'd2, 32'h0000_1001);
            check("no_pop_during_sweep", {31'd0, fifo_rd_en}, 32'd0);
            check("no_done_during_sweep", {31'd0, sweep_done}, 32'd0);
        end
        #2 reset = 1'b1;
        #1;
        check("async_reset_freq", dds_freq, 32'd0);
        check("async_reset_strobes", strobes(), 32'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_reset_freq", dds_freq, 32'd0);
            check("held_reset_strobes", strobes(), 32'b000);
        end
        reset = 1'b0;
        run_sweep(32'h0BAD_0000, 16'd2, 32'h0000_1001, 32'h0BAD_1001, 32'h0BEC_F3FF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("final_idle_strobes", strobes(), 32'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
